// File: rtl/uart_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_stream_pkg
//  Description : Shared definitions for the UART stream controller: state
//                encoding of the RUN/DRAIN controller and a ceil(log2)
//                helper used to size pointers and counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_stream_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_DRAIN = ST_DRAIN
    } stream_state_e;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_obuf.sv
`default_nettype none
// ============================================================================
//  Module      : stream_obuf
//  Description : Synchronous DEPTH x DBITS output FIFO with occupancy count.
//                A write and a read in the same cycle both take effect and
//                leave the count unchanged. The head word comes straight
//                from registered storage.
//  Ports       : clk, rst_n    - clock, asynchronous active-low reset
//                i_wr/i_wdata  - push strobe and data
//                i_rd          - pop strobe (ignored when empty)
//                o_rdata       - head word
//                o_count       - number of stored words
//                o_empty       - no words stored
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_obuf
    import uart_stream_pkg::*;
#(
    parameter int DBITS = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr,
    input  logic [DBITS-1:0]         i_wdata,
    input  logic                     i_rd,
    output logic [DBITS-1:0]         o_rdata,
    output logic [clog2(DEPTH):0]    o_count,
    output logic                     o_empty
);

    localparam int AW = clog2(DEPTH);

    logic [DBITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_empty;
    logic w_full;
    logic w_rd;
    logic w_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_rd    = i_rd && !w_empty;
    // A write into a full buffer is only legal when the head leaves the
    // same cycle; the upstream credit check keeps the other case unreachable.
    assign w_wr    = i_wr && (!w_full || w_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/uart_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_stream_ctrl
//  Description : Autonomous stream controller between the UART RX/TX FIFOs
//                and a fixed-latency filter. Words are popped from RX only
//                when a slot in the output buffer is guaranteed, routed
//                through the filter or a one-stage bypass register, and
//                pushed to TX under tx_full backpressure. An IDLE/RUN/DRAIN
//                controller makes enable and mode changes lossless.
//  Ports       : clk_100MHz, reset_btn - clock, async active-low reset
//                enable, bypass        - run request, unfiltered mode
//                rx_empty, rx_data     - RX FIFO status and FWFT head word
//                rd_uart               - RX pop strobe
//                tx_full               - TX FIFO full
//                wr_uart, wr_data      - TX push strobe and word
//                filt_x, filt_y        - filter input (registered) / output
//                state                 - 0 IDLE, 1 RUN, 2 DRAIN
//                busy                  - words in flight or buffered
//                rx_count, tx_count    - wrapping pop / push counters
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_stream_ctrl
    import uart_stream_pkg::*;
#(
    parameter int DBITS      = 8,
    parameter int FILT_LAT   = 1,
    parameter int OBUF_DEPTH = 4,
    parameter int CNT_BITS   = 16
) (
    input  logic                clk_100MHz,
    input  logic                reset_btn,
    input  logic                enable,
    input  logic                bypass,
    input  logic                rx_empty,
    input  logic [DBITS-1:0]    rx_data,
    output logic                rd_uart,
    input  logic                tx_full,
    output logic                wr_uart,
    output logic [DBITS-1:0]    wr_data,
    output logic [DBITS-1:0]    filt_x,
    input  logic [DBITS-1:0]    filt_y,
    output logic [1:0]          state,
    output logic                busy,
    output logic [CNT_BITS-1:0] rx_count,
    output logic [CNT_BITS-1:0] tx_count
);

    // Valid pipeline: bit 0 travels with filt_x, bit FILT_LAT lines up with
    // the matching filt_y, so a popped word reaches the buffer FILT_LAT+1
    // edges after its pop.
    localparam int PIPE_W = FILT_LAT + 1;
    localparam int OCW    = clog2(OBUF_DEPTH) + 1;
    localparam int CRW    = clog2(OBUF_DEPTH + PIPE_W + 2) + 1;

    stream_state_e       r_state;
    stream_state_e       w_state_nxt;
    logic                r_mode;
    logic [PIPE_W-1:0]   r_vpipe;
    logic                r_byp_vld;
    logic [DBITS-1:0]    r_filt_x;
    logic [CNT_BITS-1:0] r_rx_cnt;
    logic [CNT_BITS-1:0] r_tx_cnt;
    logic                r_busy;

    logic [CRW-1:0]      w_inflight;
    logic                w_credit_ok;
    logic                w_exit;
    logic                w_pop;
    logic                w_push;
    logic                w_ob_wr;
    logic [DBITS-1:0]    w_ob_wdata;
    logic [DBITS-1:0]    w_ob_rdata;
    logic [OCW-1:0]      w_ob_count;
    logic [OCW-1:0]      w_ob_cnt_nxt;
    logic                w_ob_empty;
    logic                w_busy_nxt;

    // ------------------------------------------------------------------
    // Credit check: everything popped but not yet written to the buffer
    // (filter pipeline plus the bypass stage) must still fit beside what
    // the buffer already holds. A push in the same cycle frees nothing.
    // ------------------------------------------------------------------
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < PIPE_W; i++) begin
            w_inflight = w_inflight + CRW'(r_vpipe[i]);
        end
        w_inflight = w_inflight + CRW'(r_byp_vld);
    end

    assign w_credit_ok = (w_inflight + CRW'(w_ob_count)) < CRW'(OBUF_DEPTH);
    assign w_exit      = !enable || (bypass != r_mode);

    // ------------------------------------------------------------------
    // Controller: next state and pop strobe. The exit condition gates the
    // pop so no word is taken on the edge that leaves RUN.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_pop = !w_exit && !rx_empty && w_credit_ok;
                if (w_exit) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_inflight == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset_btn) begin
        if (!reset_btn) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Mode is sampled only when starting a run, so a change during
            // RUN first drains the old path.
            if ((r_state == S_IDLE) && enable) begin
                r_mode <= bypass;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath. filt_x doubles as the bypass register: it always holds the
    // most recently popped word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100MHz or negedge reset_btn) begin
        if (!reset_btn) begin
            r_vpipe   <= '0;
            r_byp_vld <= 1'b0;
            r_filt_x  <= '0;
        end else begin
            r_vpipe   <= {r_vpipe[PIPE_W-2:0], w_pop & ~r_mode};
            r_byp_vld <= w_pop & r_mode;
            if (w_pop) begin
                r_filt_x <= rx_data;
            end
        end
    end

    // Only one path is ever active because the mode changes only with the
    // pipeline empty, so a plain OR is a safe write strobe.
    assign w_ob_wr    = r_byp_vld | r_vpipe[PIPE_W-1];
    assign w_ob_wdata = r_byp_vld ? r_filt_x : filt_y;
    assign w_push     = !w_ob_empty && !tx_full;

    stream_obuf #(
        .DBITS (DBITS),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk     (clk_100MHz),
        .rst_n   (reset_btn),
        .i_wr    (w_ob_wr),
        .i_wdata (w_ob_wdata),
        .i_rd    (w_push),
        .o_rdata (w_ob_rdata),
        .o_count (w_ob_count),
        .o_empty (w_ob_empty)
    );

    // ------------------------------------------------------------------
    // Counters and busy. busy is computed from the post-edge occupancy so
    // it rises on the edge of the first pop and falls on the edge of the
    // last push.
    // ------------------------------------------------------------------
    assign w_ob_cnt_nxt = w_ob_count + OCW'(w_ob_wr) - OCW'(w_push);
    assign w_busy_nxt   = (|r_vpipe[PIPE_W-2:0]) | w_pop | (w_ob_cnt_nxt != '0);

    always_ff @(posedge clk_100MHz or negedge reset_btn) begin
        if (!reset_btn) begin
            r_rx_cnt <= '0;
            r_tx_cnt <= '0;
            r_busy   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end
            if (w_push) begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign rd_uart  = w_pop;
    assign wr_uart  = w_push;
    assign wr_data  = w_ob_rdata;
    assign filt_x   = r_filt_x;
    assign state    = r_state;
    assign busy     = r_busy;
    assign rx_count = r_rx_cnt;
    assign tx_count = r_tx_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_stream_ctrl
//  Description : Self-checking bench for uart_stream_ctrl. The bench plays
//                the RX FIFO, TX FIFO and a fixed-latency filter, and keeps
//                a word-level reference model: every word carries the edge
//                at which it is due in the output buffer, and pops are
//                allowed while fewer than OBUF_DEPTH words are in the
//                system.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_stream_ctrl;

    localparam int DBITS = 8;
    localparam int FL    = 1;
    localparam int DEPTH = 4;
    localparam int CB    = 4;

    logic             clk = 1'b0;
    logic             reset_btn;
    logic             enable;
    logic             bypass;
    logic             rx_empty;
    logic [DBITS-1:0] rx_data;
    logic             rd_uart;
    logic             tx_full;
    logic             wr_uart;
    logic [DBITS-1:0] wr_data;
    logic [DBITS-1:0] filt_x;
    logic [DBITS-1:0] filt_y;
    logic [1:0]       state;
    logic             busy;
    logic [CB-1:0]    rx_count;
    logic [CB-1:0]    tx_count;

    always #5 clk = ~clk;

    uart_stream_ctrl #(
        .DBITS      (DBITS),
        .FILT_LAT   (FL),
        .OBUF_DEPTH (DEPTH),
        .CNT_BITS   (CB)
    ) dut (
        .clk_100MHz (clk),
        .reset_btn  (reset_btn),
        .enable     (enable),
        .bypass     (bypass),
        .rx_empty   (rx_empty),
        .rx_data    (rx_data),
        .rd_uart    (rd_uart),
        .tx_full    (tx_full),
        .wr_uart    (wr_uart),
        .wr_data    (wr_data),
        .filt_x     (filt_x),
        .filt_y     (filt_y),
        .state      (state),
        .busy       (busy),
        .rx_count   (rx_count),
        .tx_count   (tx_count)
    );

    // Environment filter: y = x ^ fmask, FL cycles of latency.
    logic [7:0]      fmask = 8'h00;
    logic [FL*8+7:0] fsh;
    always @(posedge clk) fsh <= {fsh[FL*8-1:0], filt_x ^ fmask};
    assign filt_y = fsh[FL*8-1 -: 8];

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        logic [7:0] val;
    } fly_t;

    fly_t       fly[$];
    logic [7:0] rxq[$];
    logic [7:0] obq[$];
    int         m_state, m_state_nxt;
    bit         m_mode, m_mode_nxt;
    int         m_rx, m_tx;
    logic [7:0] m_fx;
    int         ncyc;
    bit         exp_rd, exp_wr;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_rx();
        rx_empty = (rxq.size() == 0);
        rx_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
    endtask

    // One clock: compare at the falling edge, advance the model at the
    // rising edge, then re-drive the RX head just after it.
    task automatic step();
        int         infl;
        logic [7:0] w;
        fly_t       f;
        @(negedge clk);
        infl   = fly.size();
        exp_rd = (m_state == 1) && enable && (bypass == m_mode) &&
                 (rxq.size() > 0) && ((infl + obq.size()) < DEPTH);
        exp_wr = (obq.size() > 0) && !tx_full;
        check_eq("rd_uart", rd_uart, exp_rd);
        check_eq("wr_uart", wr_uart, exp_wr);
        if (exp_wr) check_eq("wr_data", wr_data, obq[0]);
        check_eq("state", state, m_state);
        check_eq("busy", busy, (infl + obq.size()) != 0);
        check_eq("rx_count", rx_count, m_rx % (1 << CB));
        check_eq("tx_count", tx_count, m_tx % (1 << CB));
        check_eq("filt_x", filt_x, m_fx);

        m_state_nxt = m_state;
        m_mode_nxt  = m_mode;
        case (m_state)
            0: if (enable) begin m_state_nxt = 1; m_mode_nxt = bypass; end
            1: if (!enable || (bypass != m_mode)) m_state_nxt = 2;
            2: if (infl == 0) m_state_nxt = 0;
            default: m_state_nxt = 0;
        endcase

        @(posedge clk);
        ncyc++;
        if (exp_wr) begin
            void'(obq.pop_front());
            m_tx++;
        end
        while (fly.size() > 0 && fly[0].due == ncyc) begin
            obq.push_back(fly[0].val);
            void'(fly.pop_front());
        end
        if (exp_rd) begin
            w     = rxq.pop_front();
            m_fx  = w;
            m_rx++;
            f.due = ncyc + (m_mode ? 1 : FL + 1);
            f.val = m_mode ? w : (w ^ fmask);
            fly.push_back(f);
        end
        m_state = m_state_nxt;
        m_mode  = m_mode_nxt;
        #1;
        drive_rx();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Asynchronous reset asserted away from the clock edge; outputs must
    // clear immediately.
    task automatic do_reset_now();
        reset_btn = 1'b0;
        enable    = 1'b0;
        #1;
        check_eq("rst_rd_uart", rd_uart, 0);
        check_eq("rst_wr_uart", wr_uart, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_filt_x", filt_x, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_rx_count", rx_count, 0);
        check_eq("rst_tx_count", tx_count, 0);
        check_eq("rst_state", state, 0);
        fly.delete();
        obq.delete();
        rxq.delete();
        m_state = 0;
        m_mode  = 0;
        m_rx    = 0;
        m_tx    = 0;
        m_fx    = 8'h00;
        drive_rx();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_btn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int base;
        reset_btn = 1'b1;
        enable    = 1'b0;
        bypass    = 1'b0;
        tx_full   = 1'b0;
        rx_empty  = 1'b1;
        rx_data   = 8'h00;
        ncyc      = 0;
        #2;
        do_reset_now();
        run(2);

        // Filtered run, identity filter.
        for (int i = 0; i < 5; i++) rxq.push_back(8'(8'h11 + i));
        drive_rx();
        enable = 1'b1;
        run(16);
        check_eq("t1_rx_count", rx_count, 5);
        check_eq("t1_tx_count", tx_count, 5);

        // Bypass: mode change goes through DRAIN/IDLE and restarts.
        bypass = 1'b1;
        run(6);
        rxq.push_back(8'hA5);
        drive_rx();
        run(6);
        check_eq("t2_filt_x", filt_x, 8'hA5);

        // Backpressure: only DEPTH pops while TX is full.
        tx_full = 1'b1;
        bypass  = 1'b0;
        run(6);
        base = m_rx;
        for (int i = 0; i < 10; i++) rxq.push_back(8'(8'h30 + i));
        drive_rx();
        run(15);
        check_eq("t3_pops", rx_count, (base + DEPTH) % (1 << CB));
        tx_full = 1'b0;
        run(25);
        check_eq("t3_tx", tx_count, (base + 10) % (1 << CB));

        // Mode switch after three pops.
        base = m_rx;
        for (int i = 0; i < 8; i++) rxq.push_back(8'(8'h60 + i));
        drive_rx();
        for (int k = 0; k < 50 && m_rx < base + 3; k++) step();
        check_eq("t4_pops", rx_count, (base + 3) % (1 << CB));
        bypass = 1'b1;
        run(30);
        check_eq("t4_state", state, 1);
        check_eq("t4_tx", tx_count, (base + 8) % (1 << CB));

        // Reset with two words in flight.
        bypass = 1'b0;
        run(6);
        for (int i = 0; i < 6; i++) rxq.push_back(8'(8'h90 + i));
        drive_rx();
        for (int k = 0; k < 20 && fly.size() < 2; k++) step();
        do_reset_now();
        run(6);

        // Counter wrap.
        for (int i = 0; i < 17; i++) rxq.push_back(8'(8'hC0 + i));
        drive_rx();
        enable = 1'b1;
        bypass = 1'b0;
        run(40);
        check_eq("t6_wrap_rx", rx_count, 1);
        check_eq("t6_wrap_tx", tx_count, 1);

        // Randomized traffic with a non-trivial filter.
        fmask = 8'h5A;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 45 && rxq.size() < 24) rxq.push_back(8'($urandom));
            tx_full = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 3) enable = ~enable;
            if ($urandom_range(0, 99) < 2) bypass = ~bypass;
            drive_rx();
            step();
        end
        enable  = 1'b0;
        tx_full = 1'b0;
        run(30);
        check_eq("end_state", state, 0);
        check_eq("end_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
